// File: rtl/pwm_capture_if.sv
// Signal bundle between the PWM capture block and its consumer.
// The master side is the capture block: it samples pwm_in and produces the results.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [9:0]       duty;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             valid;
  logic [1:0]       stuck;
  logic             busy;

  modport master (
    input  pwm_in,
    output duty, high_cnt, period_cnt, valid, stuck, busy
  );

  modport slave (
    output pwm_in,
    input  duty, high_cnt, period_cnt, valid, stuck, busy
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input and converts them
// to a 10-bit duty code with a serial restoring divider; also flags a stuck input.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 50000,
  parameter int MIN_PERIOD = 16
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master bus
);
  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  typedef enum logic {IDLE, DIV} div_state_t;

  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);

  logic             sync_a, sync_b, hist;
  logic             rise, fall, any_edge;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, high_cap, high_cap_n;
  logic             start_div;
  div_state_t       div_state, div_state_n;
  logic [CNT_W-1:0] div_high, div_period, rem, rem_step;
  logic [CNT_W:0]   rem_shift, trial;
  logic             take;
  logic [9:0]       quot, quot_step;
  logic [3:0]       iter;
  logic             div_done;
  logic [CNT_W-1:0] idle;
  logic             stuck_done, stuck_req, stuck_fire;
  logic [9:0]       duty_r;
  logic [CNT_W-1:0] high_r, period_r;
  logic             valid_r;
  logic [1:0]       stuck_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      hist   <= 1'b0;
    end else begin
      sync_a <= bus.pwm_in;
      sync_b <= sync_a;
      hist   <= sync_b;
    end
  end

  assign rise     = sync_b & ~hist;
  assign fall     = ~sync_b & hist;
  assign any_edge = rise | fall;
  assign cnt_inc  = (cnt == TMO) ? cnt : cnt + CNT_W'(1);

  // A stuck report waits one cycle if the divider is delivering its result.
  assign stuck_req  = (idle == TMO) && !stuck_done && !any_edge;
  assign stuck_fire = stuck_req && !div_done;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    high_cap_n = high_cap;
    start_div  = 1'b0;
    if (stuck_fire) begin
      state_n = WAIT_RISE;
      cnt_n   = '0;
    end else begin
      case (state)
        WAIT_RISE: begin
          cnt_n = '0;
          if (rise) begin
            state_n = MEAS_HIGH;
            cnt_n   = CNT_W'(1);
          end
        end
        MEAS_HIGH: begin
          cnt_n = cnt_inc;
          if (fall) begin
            high_cap_n = cnt;
            state_n    = MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          cnt_n = cnt_inc;
          if (rise) begin
            state_n   = MEAS_HIGH;
            cnt_n     = CNT_W'(1);
            start_div = (cnt >= MINP) && (div_state == IDLE);
          end
        end
        default: state_n = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_RISE;
      cnt      <= '0;
      high_cap <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      high_cap <= high_cap_n;
    end
  end

  always_comb begin
    div_state_n = div_state;
    div_done    = 1'b0;
    case (div_state)
      IDLE: if (start_div) div_state_n = DIV;
      DIV: begin
        if (iter == 4'd9) begin
          div_state_n = IDLE;
          div_done    = 1'b1;
        end
      end
      default: div_state_n = IDLE;
    endcase
  end

  // Since high < period, the remainder starts at high and the ten low dividend
  // bits are zero, so each step only shifts the remainder and trial-subtracts.
  always_comb begin
    rem_shift = {rem, 1'b0};
    trial     = rem_shift - {1'b0, div_period};
    take      = ~trial[CNT_W];
    rem_step  = take ? trial[CNT_W-1:0] : rem_shift[CNT_W-1:0];
    quot_step = quot;
    quot_step[4'd9 - iter] = take;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_state  <= IDLE;
      div_high   <= '0;
      div_period <= '0;
      rem        <= '0;
      quot       <= '0;
      iter       <= '0;
    end else begin
      div_state <= div_state_n;
      if (start_div) begin
        div_high   <= high_cap;
        div_period <= cnt;
        rem        <= high_cap;
        quot       <= '0;
        iter       <= '0;
      end else if (div_state == DIV) begin
        rem  <= rem_step;
        quot <= quot_step;
        iter <= iter + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle       <= '0;
      stuck_done <= 1'b0;
      duty_r     <= '0;
      high_r     <= '0;
      period_r   <= '0;
      valid_r    <= 1'b0;
      stuck_r    <= 2'b00;
    end else begin
      valid_r <= 1'b0;
      if (any_edge) begin
        idle       <= '0;
        stuck_done <= 1'b0;
      end else begin
        if (idle != TMO) idle <= idle + CNT_W'(1);
        if (stuck_fire) stuck_done <= 1'b1;
      end
      if (div_done) begin
        duty_r   <= quot_step;
        high_r   <= div_high;
        period_r <= div_period;
        stuck_r  <= 2'b00;
        valid_r  <= 1'b1;
      end else if (stuck_fire) begin
        duty_r  <= sync_b ? 10'd1023 : 10'd0;
        stuck_r <= sync_b ? 2'b10 : 2'b01;
        valid_r <= 1'b1;
      end
    end
  end

  assign bus.duty       = duty_r;
  assign bus.high_cnt   = high_r;
  assign bus.period_cnt = period_r;
  assign bus.valid      = valid_r;
  assign bus.stuck      = stuck_r;
  assign bus.busy       = (div_state == DIV);
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every valid pulse.
module tb_pwm_capture;
  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 6000;
  localparam int MIN_PERIOD = 16;
  localparam int LATENCY    = 13;

  typedef struct {
    int duty;
    int high;
    int period;
    int stuck;
    int rise_cyc;
    int busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.CNT_W(CNT_W)) bus();

  pwm_capture #(
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT),
    .MIN_PERIOD(MIN_PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_run = 0;
  exp_t sb[$];
  bit   pending = 1'b0;
  int   pend_high = 0;
  int   pend_period = 0;
  int   last_high = 0;
  int   last_period = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkReset(string tag);
    checkOutput({tag, "_duty"}, int'(bus.duty), 0);
    checkOutput({tag, "_high"}, int'(bus.high_cnt), 0);
    checkOutput({tag, "_period"}, int'(bus.period_cnt), 0);
    checkOutput({tag, "_stuck"}, int'(bus.stuck), 0);
    checkOutput({tag, "_valid"}, int'(bus.valid), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // A rising edge closes the pending period, which yields a result if long enough.
  task automatic riseEdge();
    exp_t e;
    bus.pwm_in = 1'b1;
    if (pending && pend_period >= MIN_PERIOD) begin
      e.duty     = (pend_high * 1024) / pend_period;
      e.high     = pend_high;
      e.period   = pend_period;
      e.stuck    = 0;
      e.rise_cyc = cyc;
      e.busy     = 10;
      sb.push_back(e);
      last_high   = pend_high;
      last_period = pend_period;
    end
  endtask

  task automatic applyStimulus(int h, int l);
    riseEdge();
    tick(h);
    bus.pwm_in = 1'b0;
    tick(l);
    pending     = 1'b1;
    pend_high   = h;
    pend_period = h + l;
  endtask

  task automatic expectStuck(bit level);
    exp_t e;
    e.duty     = level ? 1023 : 0;
    e.high     = last_high;
    e.period   = last_period;
    e.stuck    = level ? 2 : 1;
    e.rise_cyc = -1;
    e.busy     = 0;
    sb.push_back(e);
    pending = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", int'(bus.valid), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("duty", int'(bus.duty), e.duty);
          checkOutput("high_cnt", int'(bus.high_cnt), e.high);
          checkOutput("period_cnt", int'(bus.period_cnt), e.period);
          checkOutput("stuck", int'(bus.stuck), e.stuck);
          checkOutput("busy_cycles", busy_run, e.busy);
          if (e.rise_cyc >= 0) checkOutput("latency", cyc - e.rise_cyc, LATENCY);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    tick(2);
    checkReset("reset_init");
    rst = 1'b0;

    $display("[TB] stuck low from reset");
    expectStuck(1'b0);
    tick(TIMEOUT + 100);

    $display("[TB] nominal, 50%% and glitch periods");
    applyStimulus(2929, 1072);
    applyStimulus(2929, 1072);
    applyStimulus(2000, 2000);
    applyStimulus(4, 6);
    applyStimulus(2000, 2000);
    applyStimulus(2000, 2000);

    $display("[TB] stuck high and recovery");
    riseEdge();
    expectStuck(1'b1);
    tick(TIMEOUT + 100);
    bus.pwm_in = 1'b0;
    tick(100);
    applyStimulus(2929, 1072);
    applyStimulus(1000, 3000);

    $display("[TB] reset mid-high");
    riseEdge();
    tick(1000);
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    #1;
    checkReset("reset_mid_high");
    checkOutput("queue_after_reset", sb.size(), 0);
    pending = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(10);
    applyStimulus(1000, 3000);
    applyStimulus(1000, 3000);
    applyStimulus(2929, 1072);
    tick(50);
    checkOutput("missing_valid", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
